// File: rtl/piso_pkg.sv
// Shared definitions for the serial blocks: FSM state encoding and the
// helper that sizes bit counters.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Smallest counter width able to hold the index width-1 (minimum 1 bit).
  function automatic int cnt_width(input int width);
    int w;
    w = 1;
    while ((1 << w) < width) w++;
    return w;
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Saturating bit-index counter for the serializer: restarts at zero on
// rst_cnt and never advances past WIDTH-1.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          rst_cnt,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          at_last
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      count_reg <= '0;
    end else if (rst_cnt) begin
      count_reg <= '0;
    end else if (inc && !at_last) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign at_last = (count_reg == LAST_IDX);
  assign count   = count_reg;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with shift_en strobe, stall support and
// back-to-back reload in the final-bit cycle.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             done
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] shreg_reg;
  logic [WIDTH-1:0] shreg_next;
  logic             done_reg;
  logic [CW-1:0]    cnt;
  logic             at_last;
  logic             advance;
  logic             last_consumed;
  logic             accept;

  assign advance       = (state_reg == SHIFT) && shift_en;
  assign last_consumed = advance && at_last;
  // Ready in the final-bit cycle lets the next word follow with no gap.
  assign load_ready    = (state_reg == IDLE) || last_consumed;
  assign accept        = load_valid && load_ready;

  assign sout_valid = (state_reg == SHIFT);
  assign sout_last  = sout_valid && (cnt == LAST_IDX);
  assign done       = done_reg;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shreg_next = {shreg_reg[WIDTH-2:0], 1'b0};
      assign sout       = sout_valid & shreg_reg[WIDTH-1];
    end else begin : g_lsb
      assign shreg_next = {1'b0, shreg_reg[WIDTH-1:1]};
      assign sout       = sout_valid & shreg_reg[0];
    end
  endgenerate

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= last_consumed;
      if (accept) begin
        shreg_reg <= din;
        state_reg <= SHIFT;
      end else if (advance) begin
        shreg_reg <= shreg_next;
        if (at_last) state_reg <= IDLE;
      end
    end
  end

  piso_bit_cnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_bit_cnt (
    .clk     (clk),
    .clear   (clear),
    .rst_cnt (accept | last_consumed),
    .inc     (advance),
    .count   (cnt),
    .at_last (at_last)
  );

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: MSB-first and LSB-first instances share one
// stimulus stream; a bit-queue reference model predicts every output.
module tb_piso_tx;

  localparam int W = 8;

  logic         clk;
  logic         clear;
  logic [W-1:0] din;
  logic         load_valid;
  logic         shift_en;

  logic rdy_m, so_m, sv_m, sl_m, dn_m;
  logic rdy_l, so_l, sv_l, sl_l, dn_l;

  int n_cmp;
  int n_err;

  bit   qm[$];
  bit   ql[$];
  bit   done_pend;
  bit   acc_flag;
  logic [15:0] cap_m;
  logic [15:0] cap_l;
  int   done_cnt;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .clear(clear), .din(din), .load_valid(load_valid),
    .load_ready(rdy_m), .shift_en(shift_en), .sout(so_m),
    .sout_valid(sv_m), .sout_last(sl_m), .done(dn_m)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .clear(clear), .din(din), .load_valid(load_valid),
    .load_ready(rdy_l), .shift_en(shift_en), .sout(so_l),
    .sout_valid(sv_l), .sout_last(sl_l), .done(dn_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard push: the word's bits in transmit order for each instance.
  task automatic sb_push_word(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) begin
      qm.push_back(bit'((d >> (W - 1 - i)) & 1));
      ql.push_back(bit'((d >> i) & 1));
    end
  endtask

  // Monitor: compare outputs against the model, then advance the model
  // using the inputs that will be sampled on the coming rising edge.
  always @(negedge clk) begin
    bit exp_valid, exp_ready, exp_bm, exp_bl, exp_last, consumed;
    if (dn_m === 1'b1) done_cnt++;
    if (!clear) begin
      chk("rst_valid_m", sv_m, 0);
      chk("rst_sout_m",  so_m, 0);
      chk("rst_last_m",  sl_m, 0);
      chk("rst_done_m",  dn_m, 0);
      chk("rst_valid_l", sv_l, 0);
      chk("rst_sout_l",  so_l, 0);
      qm.delete();
      ql.delete();
      done_pend = 0;
      acc_flag  = 0;
    end else begin
      exp_valid = (qm.size() > 0);
      exp_bm    = exp_valid ? qm[0] : 1'b0;
      exp_bl    = exp_valid ? ql[0] : 1'b0;
      exp_last  = (qm.size() == 1);
      exp_ready = (qm.size() == 0) || ((qm.size() == 1) && shift_en);
      chk("valid_m", sv_m, exp_valid);
      chk("sout_m",  so_m, exp_bm);
      chk("last_m",  sl_m, exp_last);
      chk("ready_m", rdy_m, exp_ready);
      chk("done_m",  dn_m, done_pend);
      chk("valid_l", sv_l, exp_valid);
      chk("sout_l",  so_l, exp_bl);
      chk("last_l",  sl_l, exp_last);
      chk("ready_l", rdy_l, exp_ready);
      chk("done_l",  dn_l, done_pend);
      consumed = exp_valid && shift_en;
      if (consumed) begin
        cap_m = {cap_m[14:0], so_m};
        cap_l = {so_l, cap_l[15:1]};
      end
      done_pend = consumed && (qm.size() == 1);
      if (consumed) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      acc_flag = load_valid && exp_ready;
      if (acc_flag) sb_push_word(din);
    end
  end

  task automatic set(input bit lv, input logic [W-1:0] d, input bit se);
    load_valid = lv;
    din        = d;
    shift_en   = se;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold load_valid with d until the model sees it accepted (bounded wait).
  task automatic send(input logic [W-1:0] d, input bit se);
    set(1'b1, d, se);
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      #1;
      if (acc_flag) return;
    end
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: word %0h not accepted within 64 cycles", d);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; done_pend = 0; acc_flag = 0;
    cap_m = '0; cap_l = '0; done_cnt = 0;
    clear = 1'b0;
    set(1'b0, '0, 1'b0);
    cycles(3);
    clear = 1'b1;

    // Basic transfer, both bit orders
    cap_m = '0; cap_l = '0;
    send(8'hA5, 1'b1);
    set(1'b0, '0, 1'b1);
    cycles(10);
    chk("a5_msb_stream", cap_m[7:0], 8'hA5);
    chk("a5_lsb_stream", cap_l[15:8], 8'hA5);

    // Stall: one strobe every third cycle
    cap_m = '0;
    send(8'hF0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      set(1'b0, '0, (k % 3) == 2);
      cycles(1);
    end
    set(1'b0, '0, 1'b0);
    cycles(2);
    chk("f0_stall_stream", cap_m[7:0], 8'hF0);

    // Back-to-back reload
    cap_m = '0; done_cnt = 0;
    send(8'h81, 1'b1);
    send(8'h7E, 1'b1);
    set(1'b0, '0, 1'b1);
    cycles(10);
    chk("b2b_stream", cap_m, 16'h817E);
    chk("b2b_done_cnt", done_cnt, 2);

    // Reset mid-frame
    send(8'hFF, 1'b1);
    set(1'b0, '0, 1'b1);
    cycles(3);
    clear = 1'b0;
    done_cnt = 0;
    #1;
    chk("async_valid_m", sv_m, 0);
    chk("async_sout_m",  so_m, 0);
    chk("async_valid_l", sv_l, 0);
    chk("async_sout_l",  so_l, 0);
    cycles(2);
    clear = 1'b1;
    cap_m = '0;
    send(8'h01, 1'b1);
    set(1'b0, '0, 1'b1);
    cycles(10);
    chk("post_reset_stream", cap_m[7:0], 8'h01);
    chk("post_reset_done_cnt", done_cnt, 1);

    // Load request ignored mid-frame
    cap_m = '0;
    send(8'hC3, 1'b1);
    set(1'b0, '0, 1'b1);
    cycles(3);
    send(8'h3C, 1'b1);
    set(1'b0, '0, 1'b1);
    cycles(10);
    chk("ignored_load_stream", cap_m, 16'hC33C);

    // Randomized traffic with occasional reset
    for (int k = 0; k < 600; k++) begin
      clear = ($urandom_range(0, 99) != 0);
      set(bit'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 9) < 6);
      cycles(1);
    end
    clear = 1'b1;
    set(1'b0, '0, 1'b1);
    cycles(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
